regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (rw/wen/wdata) between two requesters.
  - Pipeline writeback: high priority.
  - Debug/host write channel: low priority, valid/ready, buffered in a small FIFO.
- Guarantees bounded debug latency through a starvation counter that briefly stalls writeback.
- Exports per-register busy flags so the decode stage interlocks reads of registers with debug writes still queued.
- Sits between writeback/debug logic and the register file.

---
 rtl/regfile_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the pipeline
//   writeback (high priority) and a debug/host write channel (low priority,
//   valid/ready, buffered in a small FIFO). A starvation counter bounds debug
//   latency by stalling writeback for one cycle to force a FIFO pop.
//   Per-register busy queries let decode interlock on queued debug writes.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wb_valid/wb_rd/wb_data      writeback request (accepted when !wb_stall)
//   wb_stall                    registered; writeback must hold its request
//   dbg_valid/dbg_ready         debug handshake (ready = FIFO not full)
//   dbg_rd/dbg_data             debug destination register and data
//   rf_wen/rf_rw/rf_wdata       registered register-file write port
//   q_ra/q_rb                   read-address queries from decode
//   q_ra_busy/q_rb_busy         combinational busy flags for the queries
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_rd,
  input  logic [31:0] dbg_data,
  output logic        rf_wen,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  q_ra,
  input  logic [4:0]  q_rb,
  output logic        q_ra_busy,
  output logic        q_rb_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 4;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    fifo_rd_mem   [DEPTH];
  logic [31:0]   fifo_data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [SW-1:0] starve_reg, starve_next;

  logic          wb_stall_reg, wb_stall_next;
  logic          rf_wen_reg, rf_wen_next;
  logic [4:0]    rf_rw_reg, rf_rw_next;
  logic [31:0]   rf_wdata_reg, rf_wdata_next;

  logic          fifo_empty;
  logic          wb_accept;
  logic          push;
  logic          pop;

  assign fifo_empty = (count_reg == '0);
  // Ready looks only at the registered count, so a same-cycle pop never
  // frees a slot for a same-cycle push.
  assign dbg_ready  = rst_n && (count_reg != FULL_CNT);
  assign wb_accept  = wb_valid && !wb_stall_reg;
  // Debug writes to x0 are consumed by the handshake but never enqueued.
  assign push       = dbg_valid && dbg_ready && (dbg_rd != 5'd0);

  assign wb_stall = wb_stall_reg;
  assign rf_wen   = rf_wen_reg;
  assign rf_rw    = rf_rw_reg;
  assign rf_wdata = rf_wdata_reg;

  // Arbitration / forced-service FSM
  always_comb begin
    state_next    = state_reg;
    starve_next   = starve_reg;
    wb_stall_next = 1'b0;
    rf_wen_next   = 1'b0;
    rf_rw_next    = rf_rw_reg;
    rf_wdata_next = rf_wdata_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_NORMAL: begin
        if (wb_accept && (wb_rd != 5'd0)) begin
          rf_wen_next   = 1'b1;
          rf_rw_next    = wb_rd;
          rf_wdata_next = wb_data;
          if (!fifo_empty && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + SW'(1);
          end
        end else if (!fifo_empty) begin
          pop           = 1'b1;
          rf_wen_next   = 1'b1;
          rf_rw_next    = fifo_rd_mem[rd_ptr_reg];
          rf_wdata_next = fifo_data_mem[rd_ptr_reg];
          starve_next   = '0;
        end
        // Stall is raised on the same edge the limit is reached, so the
        // very next cycle is guaranteed free for the forced pop.
        if (starve_next == STARVE_MAX) begin
          state_next    = ST_FORCE;
          wb_stall_next = 1'b1;
        end
      end
      ST_FORCE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          rf_wen_next   = 1'b1;
          rf_rw_next    = fifo_rd_mem[rd_ptr_reg];
          rf_wdata_next = fifo_data_mem[rd_ptr_reg];
        end
        starve_next = '0;
        state_next  = ST_NORMAL;
      end
      default: begin
        starve_next = '0;
        state_next  = ST_NORMAL;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_NORMAL;
      starve_reg   <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wb_stall_reg <= 1'b0;
      rf_wen_reg   <= 1'b0;
      rf_rw_reg    <= 5'd0;
      rf_wdata_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      starve_reg   <= starve_next;
      count_reg    <= count_next;
      wb_stall_reg <= wb_stall_next;
      rf_wen_reg   <= rf_wen_next;
      rf_rw_reg    <= rf_rw_next;
      rf_wdata_reg <= rf_wdata_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Storage needs no reset: entry validity is derived from pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= dbg_rd;
      fifo_data_mem[wr_ptr_reg] <= dbg_data;
    end
  end

  // Busy flags: an entry is live when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy count.
  logic [DEPTH-1:0] hit_a, hit_b;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] offset;
    logic          entry_valid;
    assign offset      = AW'(gi) - rd_ptr_reg;
    assign entry_valid = ({1'b0, offset} < count_reg);
    assign hit_a[gi]   = entry_valid && (fifo_rd_mem[gi] == q_ra);
    assign hit_b[gi]   = entry_valid && (fifo_rd_mem[gi] == q_rb);
  end

  assign q_ra_busy = (q_ra != 5'd0) &&
                     ((|hit_a) || (rf_wen_reg && (rf_rw_reg == q_ra)));
  assign q_rb_busy = (q_rb != 5'd0) &&
                     ((|hit_b) || (rf_wen_reg && (rf_rw_reg == q_rb)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        rf_wen;
  logic [4:0]  rf_rw;
  logic [31:0] rf_wdata;
  logic [4:0]  q_ra;
  logic [4:0]  q_rb;
  logic        q_ra_busy;
  logic        q_rb_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .rf_wen(rf_wen), .rf_rw(rf_rw), .rf_wdata(rf_wdata),
    .q_ra(q_ra), .q_rb(q_rb), .q_ra_busy(q_ra_busy), .q_rb_busy(q_rb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_wen"}, 32'(rf_wen), 32'd1);
    check({tag, "_rw"}, 32'(rf_rw), 32'(rd));
    check({tag, "_wdata"}, rf_wdata, data);
    $display("write %s: rf_wen=%0b rf_rw=%0d rf_wdata=0x%08h", tag, rf_wen, rf_rw, rf_wdata);
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    dbg_valid = 1'b0; dbg_rd = '0; dbg_data = '0; q_ra = '0; q_rb = '0;

    // Reset state
    tick();
    check("rst_wen", 32'(rf_wen), 32'd0);
    check("rst_rw", 32'(rf_rw), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    check("rst_ready_low", 32'(dbg_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", 32'(dbg_ready), 32'd1);

    // Writeback only: rd=5
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678; q_ra = 5'd5;
    #1;
    check("wb5_busy_before", 32'(q_ra_busy), 32'd0);
    tick();
    check_write("wb5", 5'd5, 32'h12345678);
    check("wb5_busy", 32'(q_ra_busy), 32'd1);
    wb_valid = 1'b0;
    tick();
    check("wb5_wen_after", 32'(rf_wen), 32'd0);
    check("wb5_busy_after", 32'(q_ra_busy), 32'd0);

    // Debug write rd=7 with idle writeback
    dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_data = 32'hA5A5A5A5; q_ra = 5'd7;
    #1;
    check("dbg7_ready", 32'(dbg_ready), 32'd1);
    tick();
    dbg_valid = 1'b0;
    check("dbg7_wen_enq", 32'(rf_wen), 32'd0);
    check("dbg7_busy_queued", 32'(q_ra_busy), 32'd1);
    tick();
    check_write("dbg7", 5'd7, 32'hA5A5A5A5);
    tick();
    check("dbg7_wen_after", 32'(rf_wen), 32'd0);
    check("dbg7_busy_after", 32'(q_ra_busy), 32'd0);

    // Fill FIFO with rd=1,2 under writeback; third request held; starvation
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'd100;
    dbg_valid = 1'b1; dbg_rd = 5'd1; dbg_data = 32'd11;
    tick();
    check_write("fill_wb10", 5'd10, 32'd100);
    wb_rd = 5'd11; wb_data = 32'd101;
    dbg_rd = 5'd2; dbg_data = 32'd22;
    #1;
    check("fill_ready1", 32'(dbg_ready), 32'd1);
    tick();
    check_write("fill_wb11", 5'd11, 32'd101);
    check("fill_full_ready", 32'(dbg_ready), 32'd0);
    wb_rd = 5'd12; wb_data = 32'd102;
    dbg_rd = 5'd9; dbg_data = 32'd33;
    q_ra = 5'd2; q_rb = 5'd1;
    #1;
    check("fill_busy2", 32'(q_ra_busy), 32'd1);
    check("fill_busy1", 32'(q_rb_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_write("fill_wb12", 5'd12, 32'd102);
      check("fill_held_ready", 32'(dbg_ready), 32'd0);
      check("fill_stall", 32'(wb_stall), (i == 2) ? 32'd1 : 32'd0);
    end
    tick();
    check_write("fill_force1", 5'd1, 32'd11);
    check("fill_force_unstall", 32'(wb_stall), 32'd0);
    check("fill_force_ready", 32'(dbg_ready), 32'd1);
    tick();
    check_write("fill_wb12_held", 5'd12, 32'd102);
    wb_valid = 1'b0; dbg_valid = 1'b0; q_ra = 5'd9;
    #1;
    check("fill_busy9", 32'(q_ra_busy), 32'd1);
    tick();
    check_write("drain2", 5'd2, 32'd22);
    tick();
    check_write("drain9", 5'd9, 32'd33);
    tick();
    check("drain_wen_after", 32'(rf_wen), 32'd0);
    check("drain_busy9_after", 32'(q_ra_busy), 32'd0);

    // Starvation with FIFO holding rd=3
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'd200;
    dbg_valid = 1'b1; dbg_rd = 5'd3; dbg_data = 32'hDEAD0003;
    tick();
    check_write("starve_wb20", 5'd20, 32'd200);
    dbg_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_rd = 5'(20 + i); wb_data = 32'(200 + i);
      tick();
      check_write("starve_wb", 5'(20 + i), 32'(200 + i));
      check("starve_stall", 32'(wb_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    wb_rd = 5'd25; wb_data = 32'd225;
    tick();
    check_write("starve_force3", 5'd3, 32'hDEAD0003);
    check("starve_unstall", 32'(wb_stall), 32'd0);
    tick();
    check_write("starve_wb25", 5'd25, 32'd225);
    wb_valid = 1'b0;
    tick();
    check("starve_wen_after", 32'(rf_wen), 32'd0);

    // x0 requests on both channels
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hEEEEEEEE;
    dbg_valid = 1'b1; dbg_rd = 5'd0; dbg_data = 32'hFFFFFFFF; q_ra = 5'd0;
    #1;
    check("x0_ready", 32'(dbg_ready), 32'd1);
    check("x0_busy", 32'(q_ra_busy), 32'd0);
    tick();
    wb_valid = 1'b0; dbg_valid = 1'b0;
    check("x0_wen1", 32'(rf_wen), 32'd0);
    check("x0_ready_after", 32'(dbg_ready), 32'd1);
    tick();
    check("x0_wen2", 32'(rf_wen), 32'd0);
    check("x0_stall", 32'(wb_stall), 32'd0);

    // Asynchronous reset mid-cycle with FIFO full and a write in flight
    wb_valid = 1'b1; wb_rd = 5'd30; wb_data = 32'd300;
    dbg_valid = 1'b1; dbg_rd = 5'd4; dbg_data = 32'd44;
    tick();
    dbg_rd = 5'd6; dbg_data = 32'd66;
    tick();
    dbg_valid = 1'b0;
    check_write("arst_pre", 5'd30, 32'd300);
    check("arst_pre_ready", 32'(dbg_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wen", 32'(rf_wen), 32'd0);
    check("arst_rw", 32'(rf_rw), 32'd0);
    check("arst_ready", 32'(dbg_ready), 32'd0);
    check("arst_stall", 32'(wb_stall), 32'd0);
    wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    q_ra = 5'd4; q_rb = 5'd6;
    #1;
    check("arst_rel_ready", 32'(dbg_ready), 32'd1);
    check("arst_rel_busy4", 32'(q_ra_busy), 32'd0);
    check("arst_rel_busy6", 32'(q_rb_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_stale", 32'(rf_wen), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
